// File: rtl/mod_step_counter.sv
// Up/down counter over 0..MAX with run-time step, wrap or saturate bounds, load and sync clear.
// Q and ovf update one edge after inputs are sampled; tc is combinational from Q and up.
module mod_step_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 2**WIDTH - 1
) (
  input  logic             clock,
  input  logic             clear_L,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             load,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  // One spare bit keeps Q+s and Q+MAX+1 from truncating.
  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   s_x;
  logic [WIDTH:0]   d_x;
  logic [WIDTH:0]   u_x;
  logic [WIDTH-1:0] next_q;
  logic             next_ovf;

  assign q_x = {1'b0, Q};
  assign d_x = {1'b0, D};
  assign s_x = ({1'b0, step} > MAX_X) ? MAX_X : {1'b0, step};
  assign u_x = q_x + s_x;

  always_comb begin
    next_q   = Q;
    next_ovf = 1'b0;
    if (sync_clear) begin
      next_q = '0;
    end else if (!en) begin
      next_q = Q;
    end else if (load) begin
      next_q = (d_x > MAX_X) ? MAX_Q : D;
    end else if (up) begin
      if (u_x <= MAX_X) begin
        next_q = WIDTH'(u_x);
      end else if (sat) begin
        next_q   = MAX_Q;
        next_ovf = 1'b1;
      end else begin
        next_q   = WIDTH'(u_x - (MAX_X + 1'b1));
        next_ovf = 1'b1;
      end
    end else begin
      if (q_x >= s_x) begin
        next_q = WIDTH'(q_x - s_x);
      end else if (sat) begin
        next_q   = '0;
        next_ovf = 1'b1;
      end else begin
        // q < s <= MAX, so the sum below always lands back inside 0..MAX.
        next_q   = WIDTH'(q_x + MAX_X + 1'b1 - s_x);
        next_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_L) begin
    if (!clear_L) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else begin
      Q   <= next_q;
      ovf <= next_ovf;
    end
  end

  assign tc = up ? (Q == MAX_Q) : (Q == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed bench for mod_step_counter: a MAX=9 instance and a full-range MAX=15 instance share stimulus.
module tb_mod_step_counter;

  logic       clock = 1'b0;
  logic       clear_L;
  logic       en, sync_clear, load, up, sat;
  logic [3:0] step, D;
  logic [3:0] q9, q15;
  logic       tc9, tc15, ovf9, ovf15;

  int n_checks = 0;
  int n_fails  = 0;

  mod_step_counter #(.WIDTH(4), .MAX(9)) u9 (
    .clock(clock), .clear_L(clear_L), .en(en), .sync_clear(sync_clear), .load(load),
    .up(up), .sat(sat), .step(step), .D(D), .Q(q9), .tc(tc9), .ovf(ovf9)
  );

  mod_step_counter #(.WIDTH(4), .MAX(15)) u15 (
    .clock(clock), .clear_L(clear_L), .en(en), .sync_clear(sync_clear), .load(load),
    .up(up), .sat(sat), .step(step), .D(D), .Q(q15), .tc(tc15), .ovf(ovf15)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [3:0] val);
    en = 1'b1; load = 1'b1; sync_clear = 1'b0; D = val;
    tick();
    load = 1'b0;
  endtask

  initial begin
    clear_L = 1'b0; en = 1'b0; sync_clear = 1'b0; load = 1'b0;
    up = 1'b0; sat = 1'b0; step = 4'd0; D = 4'd0;
    #12;
    chk("reset_q", q9, 8'd0);
    chk("reset_ovf", ovf9, 8'd0);
    chk("reset_tc_down", tc9, 8'd1);
    clear_L = 1'b1;

    // Async reset between edges
    up = 1'b1; step = 4'd1; sat = 1'b0;
    do_load(4'd5);
    chk("pre_reset_q", q9, 8'd5);
    #2;
    clear_L = 1'b0;
    #1;
    chk("async_q", q9, 8'd0);
    chk("async_ovf", ovf9, 8'd0);
    clear_L = 1'b1;
    en = 1'b1;
    tick();
    chk("post_reset_q", q9, 8'd1);
    chk("post_reset_ovf", ovf9, 8'd0);

    // Wrap up
    do_load(4'd8);
    chk("tc_q8_up", tc9, 8'd0);
    step = 4'd3; sat = 1'b0; up = 1'b1;
    tick();
    chk("wrap_up_q", q9, 8'd1);
    chk("wrap_up_ovf", ovf9, 8'd1);
    tick();
    chk("wrap_up2_q", q9, 8'd4);
    chk("wrap_up2_ovf", ovf9, 8'd0);
    do_load(4'd9);
    chk("tc_q9_up", tc9, 8'd1);
    up = 1'b0;
    #1;
    chk("tc_q9_down", tc9, 8'd0);

    // Wrap down
    do_load(4'd1);
    up = 1'b0; sat = 1'b0; step = 4'd3;
    tick();
    chk("wrap_dn_q", q9, 8'd8);
    chk("wrap_dn_ovf", ovf9, 8'd1);

    // Saturate down, repeated overflow, then zero step
    do_load(4'd2);
    chk("load_clears_ovf", ovf9, 8'd0);
    sat = 1'b1;
    tick();
    chk("sat_dn_q", q9, 8'd0);
    chk("sat_dn_ovf", ovf9, 8'd1);
    tick();
    chk("sat_dn2_q", q9, 8'd0);
    chk("sat_dn2_ovf", ovf9, 8'd1);
    step = 4'd0;
    tick();
    chk("step0_q", q9, 8'd0);
    chk("step0_ovf", ovf9, 8'd0);

    // Load clamp, sync_clear over load, step clamp
    do_load(4'd14);
    chk("load_clamp_q", q9, 8'd9);
    chk("load_clamp_q15", q15, 8'd14);
    load = 1'b1; D = 4'd3; sync_clear = 1'b1;
    tick();
    chk("sclr_over_load", q9, 8'd0);
    load = 1'b0; sync_clear = 1'b0; step = 4'd15; up = 1'b1; sat = 1'b0;
    tick();
    chk("step_clamp_q", q9, 8'd9);
    chk("step_clamp_ovf", ovf9, 8'd0);

    // Enable gating, then sync_clear while disabled
    do_load(4'd4);
    en = 1'b0; up = 1'b1; step = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en0_q", q9, 8'd4);
      chk("en0_ovf", ovf9, 8'd0);
    end
    sync_clear = 1'b1;
    tick();
    chk("sclr_en0_q", q9, 8'd0);
    sync_clear = 1'b0;

    // Full-range instance
    do_load(4'd15);
    chk("full_load_q", q15, 8'd15);
    up = 1'b1; step = 4'd1; sat = 1'b0;
    tick();
    chk("full_wrap_q", q15, 8'd0);
    chk("full_wrap_ovf", ovf15, 8'd1);
    do_load(4'd15);
    sat = 1'b1;
    tick();
    chk("full_sat_q", q15, 8'd15);
    chk("full_sat_ovf", ovf15, 8'd1);
    chk("max9_sat_q", q9, 8'd9);
    chk("max9_sat_ovf", ovf9, 8'd1);
    #2;
    clear_L = 1'b0;
    #1;
    chk("async_ovf15", ovf15, 8'd0);
    chk("async_q15", q15, 8'd0);
    clear_L = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
